// File: rtl/cla_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cla_pipe
// Description : Pipelined carry-lookahead adder/subtractor. The WIDTH-bit word
//               is cut into STAGES equal slices of SW = WIDTH/STAGES bits.
//               Stage k adds slice k with a two-level lookahead (4-bit groups,
//               then a group lookahead) and registers the slice carry for
//               stage k+1. Operands that are still waiting to be added travel
//               down the pipe with the beat. Finished low sum slices are carried
//               forward so that the whole of s appears in one beat.
//               Flow control is valid/ready on both sides. There is one global
//               advance enable, so bubbles are kept rather than collapsed.
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready, a, b, ci, sub    - operand beat
//               out_valid/out_ready, s, co, ovf,
//               pg, gg                              - result beat
// Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe #(
    parameter int WIDTH  = 32,   // operand width, a multiple of 4*STAGES
    parameter int STAGES = 4     // pipeline depth (= latency in cycles)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             pg,
    output logic             gg
);

    localparam int SW = WIDTH / STAGES;  // slice width
    localparam int NG = SW / 4;          // 4-bit groups per slice

    // ------------------------------------------------------------------
    // Lookahead helpers
    // ------------------------------------------------------------------

    // Carries into bits 0..3 of a 4-bit group, given the group carry-in.
    // Bit 3's p/g only matter for the group generate, so they are not inputs.
    function automatic logic [3:0] bit_carries(input logic [2:0] p,
                                               input logic [2:0] g,
                                               input logic       c);
        logic [3:0] r;
        r[0] = c;
        r[1] = g[0] | (p[0] & c);
        r[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        r[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c);
        return r;
    endfunction

    // Group generate of a 4-bit group.
    function automatic logic grp_gen(input logic [3:0] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Carries into each group (index 0..NG-1) plus the slice carry-out
    // (index NG). Each carry is a flat sum of products of group p/g and the
    // slice carry-in, so nothing ripples from one group to the next.
    function automatic logic [NG:0] grp_carries(input logic [NG-1:0] gp,
                                                input logic [NG-1:0] gg_in,
                                                input logic          c);
        logic [NG:0] r;
        logic        term;
        logic        acc;
        for (int j = 0; j <= NG; j++) begin
            term = c;
            for (int i = 0; i < j; i++) begin
                term = term & gp[i];
            end
            acc = term;
            for (int i = 0; i < j; i++) begin
                term = gg_in[i];
                for (int m = i + 1; m < j; m++) begin
                    term = term & gp[m];
                end
                acc = acc | term;
            end
            r[j] = acc;
        end
        return r;
    endfunction

    // Slice generate: the slice carry-out with a zero carry-in.
    function automatic logic slice_gen(input logic [NG-1:0] gp,
                                       input logic [NG-1:0] gg_in);
        logic term;
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < NG; i++) begin
            term = gg_in[i];
            for (int m = i + 1; m < NG; m++) begin
                term = term & gp[m];
            end
            acc = acc | term;
        end
        return acc;
    endfunction

    // ------------------------------------------------------------------
    // Stage registers (index k = output of stage k)
    // ------------------------------------------------------------------
    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];   // operand A, travelling with the beat
    logic [WIDTH-1:0] r_b   [STAGES];   // operand B (raw, inverted per slice)
    logic             r_sub [STAGES];
    logic             r_c   [STAGES];   // slice carry-out
    logic             r_pg  [STAGES];   // running word propagate
    logic             r_gg  [STAGES];   // running word generate
    logic [WIDTH-1:0] r_s   [STAGES];   // sum bits finished so far
    logic             r_ovf;

    // Stage inputs and combinational slice results
    logic             w_vin   [STAGES];
    logic [WIDTH-1:0] w_ain   [STAGES];
    logic [WIDTH-1:0] w_bin   [STAGES];
    logic             w_subin [STAGES];
    logic             w_cin   [STAGES];
    logic             w_pgin  [STAGES];
    logic             w_ggin  [STAGES];
    logic [WIDTH-1:0] w_snew  [STAGES];
    logic             w_cout  [STAGES];
    logic             w_spg   [STAGES];
    logic             w_sgg   [STAGES];
    logic             w_cmsb  [STAGES];  // carry into the slice MSB

    logic w_en;

    // A stalled, occupied output slot freezes the whole pipe.
    assign w_en     = !r_vld[STAGES-1] | out_ready;
    assign in_ready = w_en;

    // ------------------------------------------------------------------
    // Per-stage slice adder
    // ------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]    w_as;
        logic [SW-1:0]    w_bs;
        logic [SW-1:0]    w_be;
        logic [SW-1:0]    w_p;
        logic [SW-1:0]    w_g;
        logic [SW-1:0]    w_c;
        logic [SW-1:0]    w_sum;
        logic [NG-1:0]    w_gp;
        logic [NG-1:0]    w_gg;
        logic [NG:0]      w_gc;
        logic [WIDTH-1:0] w_sprev;
        logic [WIDTH-1:0] w_sn;

        if (k == 0) begin : g_head
            assign w_vin[k]   = in_valid;
            assign w_ain[k]   = a;
            assign w_bin[k]   = b;
            assign w_subin[k] = sub;
            // For subtraction the borrow-in becomes an inverted carry-in.
            assign w_cin[k]   = ci ^ sub;
            assign w_pgin[k]  = 1'b1;
            assign w_ggin[k]  = 1'b0;
            assign w_sprev    = '0;
        end else begin : g_body
            assign w_vin[k]   = r_vld[k-1];
            assign w_ain[k]   = r_a[k-1];
            assign w_bin[k]   = r_b[k-1];
            assign w_subin[k] = r_sub[k-1];
            assign w_cin[k]   = r_c[k-1];
            assign w_pgin[k]  = r_pg[k-1];
            assign w_ggin[k]  = r_gg[k-1];
            assign w_sprev    = r_s[k-1];
        end

        assign w_as = w_ain[k][k*SW +: SW];
        assign w_bs = w_bin[k][k*SW +: SW];
        assign w_be = w_subin[k] ? ~w_bs : w_bs;
        assign w_p  = w_as ^ w_be;
        assign w_g  = w_as & w_be;

        for (genvar j = 0; j < NG; j++) begin : g_grp
            assign w_gp[j]        = &w_p[4*j +: 4];
            assign w_gg[j]        = grp_gen(w_p[4*j +: 4], w_g[4*j +: 4]);
            assign w_c[4*j +: 4]  = bit_carries(w_p[4*j +: 3], w_g[4*j +: 3],
                                                w_gc[j]);
        end

        assign w_gc      = grp_carries(w_gp, w_gg, w_cin[k]);
        assign w_sum     = w_p ^ w_c;
        assign w_spg[k]  = &w_gp;
        assign w_sgg[k]  = slice_gen(w_gp, w_gg);
        assign w_cout[k] = w_gc[NG];
        assign w_cmsb[k] = w_c[SW-1];

        // Lower slices come from the previous stage; this slice is new.
        always_comb begin
            w_sn              = w_sprev;
            w_sn[k*SW +: SW]  = w_sum;
        end
        assign w_snew[k] = w_sn;
    end

    // ------------------------------------------------------------------
    // Pipeline registers. Data only loads behind a valid beat so the
    // outputs keep their last value across bubbles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sub[k] <= 1'b0;
                r_c[k]   <= 1'b0;
                r_pg[k]  <= 1'b0;
                r_gg[k]  <= 1'b0;
                r_s[k]   <= '0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_vin[k];
                if (w_vin[k]) begin
                    r_a[k]   <= w_ain[k];
                    r_b[k]   <= w_bin[k];
                    r_sub[k] <= w_subin[k];
                    r_c[k]   <= w_cout[k];
                    r_pg[k]  <= w_pgin[k] & w_spg[k];
                    r_gg[k]  <= w_sgg[k] | (w_spg[k] & w_ggin[k]);
                    r_s[k]   <= w_snew[k];
                end
            end
            if (w_vin[STAGES-1]) begin
                r_ovf <= w_cmsb[STAGES-1] ^ w_cout[STAGES-1];
            end
        end
    end

    // Operand copies in the last stage and the lower operand bits of later
    // stages are never consumed; fold them here so the intent is explicit.
    logic w_unused;
    always_comb begin
        w_unused = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            w_unused = w_unused ^ (^r_a[k]) ^ (^r_b[k]) ^ r_sub[k] ^ w_cmsb[k];
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign s         = r_s[STAGES-1];
    assign co        = r_c[STAGES-1];
    assign pg        = r_pg[STAGES-1];
    assign gg        = r_gg[STAGES-1];
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_pipe
// Description : Self-checking bench for cla_pipe (WIDTH=32, STAGES=4).
//               Accepted beats are scored against an arithmetic reference
//               model through an in-order queue; directed cases compare
//               against fixed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    logic             pg;
    logic             gg;

    cla_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf),
        .pg        (pg),
        .gg        (gg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] res;   // {co, ovf, pg, gg, s}
        int          acc;   // cycle in which the beat was accepted
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: plain 33-bit arithmetic on the effective operands.
    function automatic logic [35:0] ref_model(input logic [31:0] ta,
                                              input logic [31:0] tb_v,
                                              input logic tci, input logic tsub);
        logic [31:0] bp;
        logic [32:0] full;
        logic [32:0] nc;
        logic        cin;
        logic        v;
        bp   = tsub ? ~tb_v : tb_v;
        cin  = tsub ? ~tci : tci;
        full = {1'b0, ta} + {1'b0, bp} + {32'd0, cin};
        nc   = {1'b0, ta} + {1'b0, bp};
        // Signed overflow: like-signed operands giving an unlike-signed sum.
        v    = (ta[31] == bp[31]) && (full[31] != ta[31]);
        return {full[32], v, &(ta ^ bp), nc[32], full[31:0]};
    endfunction

    function automatic logic [35:0] dut_res();
        return {co, ovf, pg, gg, s};
    endfunction

    // One clock cycle: drive, sample handshakes, advance to edge+1.
    task automatic step(input logic iv, input logic [31:0] ia,
                        input logic [31:0] ib, input logic ici,
                        input logic isub, input logic ordy, input bit lat);
        exp_t e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        ci        = ici;
        sub       = isub;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", 64'(dut_res()), 64'(e.res));
                if (lat) chk("latency", 64'(cyc - e.acc), 64'(STAGES));
            end
        end
        if (in_valid && in_ready) begin
            e.res = ref_model(ia, ib, ici, isub);
            e.acc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input bit lat);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, lat);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("idle_after_drain", 64'(out_valid), 64'd0);
    endtask

    task automatic directed(input string tag, input logic [31:0] ta,
                            input logic [31:0] tb_v, input logic tci,
                            input logic tsub, input logic [35:0] exp_v);
        int acc;
        int n;
        acc = cyc;
        step(1'b1, ta, tb_v, tci, tsub, 1'b1, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        chk({tag, "_latency"}, 64'(cyc - acc), 64'(STAGES));
        chk({tag, "_value"}, 64'(dut_res()), 64'(exp_v));
        drain(1'b0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [35:0] snap;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rci;
        logic        rsub;
        logic        riv;
        logic        rrdy;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_outputs", 64'(dut_res()), 64'd0);

        // Directed arithmetic corner cases {co, ovf, pg, gg, s}
        directed("inc_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                 {1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0000});
        directed("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                 {1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0000});
        directed("neg_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
                 {1'b1, 1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF});
        directed("full_prop", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0,
                 {1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000});

        // Async reset with beats in flight: nothing may ever emerge
        step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h0F0F_0F0F, 32'h2222_2222, 1'b1, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_outputs", 64'(dut_res()), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("no_ghost_beat", 64'(out_valid), 64'd0);
        end

        // Streaming: 8 back-to-back beats, each exactly STAGES cycles late
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'(i), 32'(i) << 16, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        drain(1'b1);

        // Backpressure on a full pipe
        for (int i = 0; i < 6; i++) begin
            step(1'b1, $urandom, $urandom, 1'($urandom % 2), 1'($urandom % 2),
                 1'b1, 1'b0);
        end
        chk("full_before_stall", 64'(out_valid), 64'd1);
        snap = dut_res();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_hold", 64'(dut_res()), 64'(snap));
        end
        drain(1'b0);

        // Randomised valid/ready with mixed operands
        for (int i = 0; i < 400; i++) begin
            ra   = ($urandom % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
            rb   = ($urandom % 8 == 0) ? 32'h8000_0000 : $urandom;
            rci  = 1'($urandom % 2);
            rsub = 1'($urandom % 2);
            riv  = ($urandom % 4) != 0;
            rrdy = ($urandom % 3) != 0;
            step(riv, ra, rb, rci, rsub, rrdy, 1'b0);
        end
        drain(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
